// File: rtl/ram_loader_pkg.sv
// Shared definitions for the serial RAM image loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // Width of the LEN byte on the stream.
    localparam int unsigned LEN_BYTE_W = 8;

    // LEN byte value that fills a RAM of the given address width.
    function automatic int unsigned max_len(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Loads a length-prefixed byte stream into RAM while holding the CPU in reset.
// Optional trailing checksum byte is checked when LOADER_CHECKSUM_EN is defined.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int unsigned CW      = ADDR_WIDTH + 1;
    localparam int unsigned MAX_LEN = max_len(ADDR_WIDTH);

    loader_state_t state;
    logic [CW-1:0] len;
    logic [CW-1:0] cnt_next;
    logic          accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
    logic [7:0]    sum_next;
`endif

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            ST_LEN, ST_LOAD: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:        rx_ready = 1'b1;
`endif
            default:         rx_ready = 1'b0;
        endcase
    end

    assign accept   = rx_valid && rx_ready;
    assign cnt_next = byte_count + CW'(1);
`ifdef LOADER_CHECKSUM_EN
    assign sum_next = sum + rx_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len        <= '0;
            byte_count <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LEN;
                        byte_count <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_reset  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (rx_data == 8'd0 || 32'(rx_data) > MAX_LEN) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            len   <= CW'(rx_data);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        // Count is below len (<= depth) here, so the low bits never wrap.
                        ram_we     <= 1'b1;
                        ram_addr   <= byte_count[ADDR_WIDTH-1:0];
                        ram_wdata  <= rx_data;
                        byte_count <= cnt_next;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= sum_next;
                        if (cnt_next == len) begin
                            state <= ST_CHECK;
                        end
`else
                        if (cnt_next == len) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (sum_next == 8'd0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader (ADDR_WIDTH=4); follows LOADER_CHECKSUM_EN if defined.
module tb_ram_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   byte_count;

    ram_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned first;
        int unsigned n;
        bit          gap;
        bit          poke;
        bit          exp_done;
        bit          exp_err;
        int unsigned exp_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  pool[$];
    logic [11:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int unsigned n, input bit gap, input bit poke,
                           input bit exp_done, input bit exp_err, input int unsigned exp_cnt);
        vec_t v;
        v.first = pool.size() - n;
        v.n = n; v.gap = gap; v.poke = poke;
        v.exp_done = exp_done; v.exp_err = exp_err; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte and wait (bounded) for the edge that takes it.
    task automatic send(input logic [7:0] b, input bit exp_write, input int unsigned addr);
        int unsigned tries = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!rx_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        if (exp_write) exp_q.push_back({4'(addr), b});
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_session_start();
        chk("start_rx_ready", rx_ready, 1);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_byte_count", byte_count, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned len;
        pulse_start();
        check_session_start();
        len = pool[v.first];
        for (int unsigned i = 0; i < v.n; i++) begin
            bit wr;
            wr = (len >= 1 && len <= 16 && i >= 1 && i <= len);
            send(pool[v.first + i], wr, i - 1);
            if (i + 1 < v.n && (v.gap || (v.poke && i == 2))) begin
                start = v.poke && i == 2;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        chk("end_done", done, v.exp_done);
        chk("end_error", error, v.exp_err);
        chk("end_cpu_reset", cpu_reset, !v.exp_done);
        chk("end_byte_count", byte_count, v.exp_cnt);
        // Bytes offered after the session must be refused.
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("stray_rx_ready", rx_ready, 0);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        chk("stray_done_hold", done, v.exp_done);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] s;
        reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        // Scoreboard: every RAM write must match the oldest expectation.
        fork
            forever begin
                @(negedge clk);
                if (ram_we === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_we", {20'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
                    end else begin
                        chk("ram_write", {20'd0, ram_addr, ram_wdata}, {20'd0, exp_q.pop_front()});
                    end
                end
            end
        join_none

`ifdef LOADER_CHECKSUM_EN
        pool.push_back(8'h02); pool.push_back(8'hAB); pool.push_back(8'hCD); pool.push_back(8'h88);
        add_vec(4, 0, 0, 1, 0, 2);
        pool.push_back(8'h01); pool.push_back(8'hAB); pool.push_back(8'h00);
        add_vec(3, 0, 0, 0, 1, 1);
        pool.push_back(8'h00);
        add_vec(1, 0, 0, 0, 1, 0);
        pool.push_back(8'h11);
        add_vec(1, 0, 0, 0, 1, 0);
        pool.push_back(8'h10);
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pool.push_back(8'(i * 8'h11 + 8'h03));
            s = s + 8'(i * 8'h11 + 8'h03);
        end
        pool.push_back(8'(8'h00 - s));
        add_vec(18, 1, 0, 1, 0, 16);
        pool.push_back(8'h03); pool.push_back(8'h11); pool.push_back(8'h22);
        pool.push_back(8'h33); pool.push_back(8'h9A);
        add_vec(5, 0, 1, 1, 0, 3);
`else
        s = 8'h00;
        pool.push_back(8'h01); pool.push_back(8'hAB);
        add_vec(2, 0, 0, 1, 0, 1);
        pool.push_back(8'h02); pool.push_back(8'hAB); pool.push_back(8'hCD);
        add_vec(3, 0, 0, 1, 0, 2);
        pool.push_back(8'h00);
        add_vec(1, 0, 0, 0, 1, 0);
        pool.push_back(8'h11);
        add_vec(1, 0, 0, 0, 1, 0);
        pool.push_back(8'h10);
        for (int i = 0; i < 16; i++) pool.push_back(8'(i * 8'h11 + 8'h03));
        add_vec(17, 1, 0, 1, 0, 16);
        pool.push_back(8'h03); pool.push_back(8'h11); pool.push_back(8'h22); pool.push_back(8'h33);
        add_vec(4, 0, 1, 1, 0, 3);
`endif

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_byte_count", byte_count, 0);

        // Start is the only way out of IDLE; bytes there are ignored.
        rx_data = 8'h01; rx_valid = 1'b1;
        @(posedge clk); #1;
        chk("idle_rx_ready", rx_ready, 0);
        rx_valid = 1'b0;

        for (int unsigned v = 0; v < vecs.size(); v++) run_vec(vecs[v]);

        // Reset in the middle of a 5-byte load.
        pulse_start();
        check_session_start();
        send(8'h05, 0, 0);
        for (int unsigned i = 0; i < 3; i++) send(8'(8'h40 + i), 1, i);
        chk("midload_count", byte_count, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_byte_count", byte_count, 0);
        chk("midrst_done", done, 0);
        pulse_start();
        check_session_start();
        send(8'h01, 0, 0);
        send(8'h55, 1, 0);
`ifdef LOADER_CHECKSUM_EN
        send(8'hAB, 0, 0);
`endif
        chk("after_rst_done", done, 1);
        chk("after_rst_cpu_reset", cpu_reset, 0);
        chk("after_rst_count", byte_count, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("final_pending_writes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning RAM address width (depth = 2**ADDR_WIDTH bytes).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have the following ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load session (sampled in IDLE, DONE, ERROR only).
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- ram_we  output  1  RAM write strobe, one cycle per data byte.
- ram_addr  output  ADDR_WIDTH  RAM write address.
- ram_wdata  output  8  RAM write data.
- cpu_reset  output  1  holds the computer in reset while high.
- done  output  1  image loaded; CPU released.
- error  output  1  load aborted.
- byte_count  output  ADDR_WIDTH+1  data bytes written this session.

Function
REQ-004 SHALL implement states IDLE, LEN, LOAD, CHECK, DONE, ERROR.
REQ-005 Handshake: a byte transfers only on a clk edge with rx_valid=1 and rx_ready=1; rx_ready=1 only in LEN, LOAD, CHECK.
REQ-006 Transition: IDLE/DONE/ERROR with start=1 -> LEN; clear byte_count, done, error, checksum accumulator; drive cpu_reset=1.
REQ-007 LEN: the accepted byte is length N; N=0 or N>2**ADDR_WIDTH -> ERROR; otherwise -> LOAD.
REQ-008 LOAD: the k-th accepted byte (k=0..N-1) SHALL produce ram_we=1 on the following cycle with ram_addr=k and ram_wdata=byte (latency 1); ram_we is 0 on all other cycles.
REQ-009 byte_count SHALL increment with each LOAD acceptance; the N-th acceptance -> CHECK (macro set) or DONE (macro clear).
REQ-010 Address SHALL never wrap; N=2**ADDR_WIDTH writes addresses 0..2**ADDR_WIDTH-1 exactly once.
REQ-011 DONE: done=1, cpu_reset=0, held until reset or start.
REQ-012 ERROR: error=1, cpu_reset=1, no RAM writes, held until reset or start.
REQ-013 start SHALL be ignored in LEN, LOAD, CHECK.
REQ-014 Bytes offered in IDLE, DONE, ERROR SHALL be neither accepted nor written.
REQ-015 rx_valid gaps of any length SHALL be tolerated without timeout.

Reset
REQ-016 reset SHALL override all other inputs and force IDLE on the next edge, including mid-LOAD.
REQ-017 Reset values SHALL be rx_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset=1, done=0, error=0, byte_count=0.

Configuration
REQ-018 Macro LOADER_CHECKSUM_EN defined: CHECK state present; the 8-bit sum mod 256 of all N data bytes plus the checksum byte SHALL be 0 -> DONE, else ERROR; RAM contents already written are not rolled back.
REQ-019 Macro LOADER_CHECKSUM_EN undefined: no CHECK state or accumulator; the last data byte -> DONE directly.

Structure
REQ-020 Shared package SHALL hold the loader state enum typedef and the LEN-byte encoding constant for max depth.
REQ-021 No sub-module; FSM, address counter and checksum accumulator SHALL be inline.

Verification
REQ-022 Macro set, ADDR_WIDTH=4: start, stream 02,AB,CD,88 -> writes mem[0]=AB, mem[1]=CD; done=1, cpu_reset=0, byte_count=2.
REQ-023 Macro set: stream 01,AB,00 -> ERROR, error=1, cpu_reset=1, mem[0]=AB written.
REQ-024 Length 00 and length 11h -> ERROR, no ram_we pulse.
REQ-025 N=10h with rx_valid toggled every other cycle -> 16 writes to addresses 0..F in order, no wrap, done=1.
REQ-026 reset asserted after 3 of 5 data bytes -> next edge IDLE, ram_we=0, cpu_reset=1, byte_count=0; new start with 01,55,ABh -> done=1.
REQ-027 Macro clear: stream 01,AB -> mem[0]=AB, done=1 on the cycle after acceptance, no checksum byte consumed.
